// File: rtl/fre_pkg.sv
// fre_pkg: shared widths, reference clock and FSM encoding for the frequency calculator.
package fre_pkg;

   localparam int unsigned CNT_WIDTH = 32;
   localparam int unsigned CLK_FRE   = 200000000;
   localparam int unsigned Q_WIDTH   = 32;
   localparam int unsigned NUM_W     = 2 * CNT_WIDTH;

   localparam logic [Q_WIDTH-1:0] FRE_SAT_VAL = '1;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MUL  = 2'd1,
      ST_DIV  = 2'd2,
      ST_DONE = 2'd3
   } fre_state_e;

endpackage

// File: rtl/fre_calc_seq_divider.sv
// seq_divider: restoring divider, one quotient bit per cycle MSB first, N_W iterations after start.
module seq_divider #(
   parameter int unsigned N_W = 64,
   parameter int unsigned D_W = 32
) (
   input  logic           clk,
   input  logic           rst_or,
   input  logic           start,
   input  logic [N_W-1:0] dividend,
   input  logic [D_W-1:0] divisor,
   output logic           busy,
   output logic           done,
   output logic [N_W-1:0] quotient,
   output logic [D_W-1:0] remainder
);

   localparam int unsigned CNT_W = $clog2(N_W + 1);

   logic [N_W-1:0]   quo_q, quo_d;
   logic [D_W-1:0]   rem_q, rem_d;
   logic [D_W-1:0]   dsr_q, dsr_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [D_W:0]     rem_sh;
   logic [D_W:0]     diff;

   // NOTE: every signal assigned in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
   always_comb begin
      quo_d  = quo_q;
      rem_d  = rem_q;
      dsr_d  = dsr_q;
      cnt_d  = cnt_q;
      rem_sh = {rem_q, quo_q[N_W-1]};
      diff   = rem_sh - {1'b0, dsr_q};
      if (start && (cnt_q == '0)) begin
         quo_d = dividend;
         rem_d = '0;
         dsr_d = divisor;
         cnt_d = CNT_W'(N_W);
      end else if (cnt_q != '0) begin
         // The dividend register doubles as the quotient shift register.
         if (rem_sh >= {1'b0, dsr_q}) begin
            rem_d = diff[D_W-1:0];
            quo_d = {quo_q[N_W-2:0], 1'b1};
         end else begin
            rem_d = rem_sh[D_W-1:0];
            quo_d = {quo_q[N_W-2:0], 1'b0};
         end
         cnt_d = cnt_q - 1'b1;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
   always_ff @(posedge clk or posedge rst_or) begin
      if (rst_or) begin
         quo_q <= '0;
         rem_q <= '0;
         dsr_q <= '0;
         cnt_q <= '0;
      end else begin
         quo_q <= quo_d;
         rem_q <= rem_d;
         dsr_q <= dsr_d;
         cnt_q <= cnt_d;
      end
   end

   assign busy      = (cnt_q != '0);
   assign done      = (cnt_q == CNT_W'(1));
   assign quotient  = quo_q;
   assign remainder = rem_q;

endmodule

// File: rtl/fre_calc.sv
// fre_calc: turns a locked (sig_cnt, gate_cnt) pair into Hz as sig_cnt*CLK_FRE/gate_cnt.
// Define FRE_CALC_ROUND_EN to round to nearest (half up) instead of truncating.
module fre_calc
   import fre_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst_or,
   input  logic                 cnt_valid,
   input  logic [CNT_WIDTH-1:0] sig_cnt,
   input  logic [CNT_WIDTH-1:0] gate_cnt,
   output logic [Q_WIDTH-1:0]   fre_out,
   output logic                 fre_valid,
   output logic                 busy,
   output logic                 div_err,
   output logic                 fre_sat,
   output logic                 overrun
);

   fre_state_e state_q, state_d;

   logic cv_meta_q, cv_meta_d;
   logic cv_sync_q, cv_sync_d;
   logic cv_dly_q,  cv_dly_d;
   logic rise;

   logic [CNT_WIDTH-1:0] sig_q,  sig_d;
   logic [CNT_WIDTH-1:0] gate_q, gate_d;
   logic [Q_WIDTH-1:0]   fre_out_q, fre_out_d;
   logic                 fre_valid_q, fre_valid_d;
   logic                 div_err_q, div_err_d;
   logic                 fre_sat_q, fre_sat_d;
   logic                 overrun_q, overrun_d;

   logic [NUM_W-1:0]     num;
   logic                 div_start;
   logic                 div_done;
   logic                 div_busy_unused;
   logic [NUM_W-1:0]     quo;
   logic [CNT_WIDTH-1:0] div_rem_unused;

   always_comb begin
      cv_meta_d = cnt_valid;
      cv_sync_d = cv_meta_q;
      cv_dly_d  = cv_sync_q;
   end

   assign rise = cv_sync_q & ~cv_dly_q;

   always_comb begin
      num = NUM_W'(sig_q) * NUM_W'(CLK_FRE);
`ifdef FRE_CALC_ROUND_EN
      num = num + NUM_W'(gate_q >> 1);
`endif
   end

   seq_divider #(
      .N_W (NUM_W),
      .D_W (CNT_WIDTH)
   ) u_div (
      .clk       (clk),
      .rst_or    (rst_or),
      .start     (div_start),
      .dividend  (num),
      .divisor   (gate_q),
      .busy      (div_busy_unused),
      .done      (div_done),
      .quotient  (quo),
      .remainder (div_rem_unused)
   );

   always_comb begin
      state_d     = state_q;
      sig_d       = sig_q;
      gate_d      = gate_q;
      fre_out_d   = fre_out_q;
      fre_valid_d = 1'b0;
      div_err_d   = div_err_q;
      fre_sat_d   = fre_sat_q;
      overrun_d   = 1'b0;
      div_start   = 1'b0;

      // A rise in any non-IDLE state, DONE included, is dropped.
      if (rise && (state_q != ST_IDLE)) begin
         overrun_d = 1'b1;
      end

      case (state_q)
         ST_IDLE: begin
            if (rise) begin
               sig_d   = sig_cnt;
               gate_d  = gate_cnt;
               state_d = ST_MUL;
            end
         end
         ST_MUL: begin
            if (gate_q == '0) begin
               state_d = ST_DONE;
            end else begin
               div_start = 1'b1;
               state_d   = ST_DIV;
            end
         end
         ST_DIV: begin
            if (div_done) begin
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            fre_valid_d = 1'b1;
            state_d     = ST_IDLE;
            if (gate_q == '0) begin
               fre_out_d = FRE_SAT_VAL;
               div_err_d = 1'b1;
               fre_sat_d = 1'b0;
            end else if (|quo[NUM_W-1:Q_WIDTH]) begin
               fre_out_d = FRE_SAT_VAL;
               div_err_d = 1'b0;
               fre_sat_d = 1'b1;
            end else begin
               fre_out_d = quo[Q_WIDTH-1:0];
               div_err_d = 1'b0;
               fre_sat_d = 1'b0;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst_or) begin
      if (rst_or) begin
         state_q     <= ST_IDLE;
         cv_meta_q   <= 1'b0;
         cv_sync_q   <= 1'b0;
         cv_dly_q    <= 1'b0;
         sig_q       <= '0;
         gate_q      <= '0;
         fre_out_q   <= '0;
         fre_valid_q <= 1'b0;
         div_err_q   <= 1'b0;
         fre_sat_q   <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         cv_meta_q   <= cv_meta_d;
         cv_sync_q   <= cv_sync_d;
         cv_dly_q    <= cv_dly_d;
         sig_q       <= sig_d;
         gate_q      <= gate_d;
         fre_out_q   <= fre_out_d;
         fre_valid_q <= fre_valid_d;
         div_err_q   <= div_err_d;
         fre_sat_q   <= fre_sat_d;
         overrun_q   <= overrun_d;
      end
   end

   assign fre_out   = fre_out_q;
   assign fre_valid = fre_valid_q;
   assign busy      = (state_q != ST_IDLE);
   assign div_err   = div_err_q;
   assign fre_sat   = fre_sat_q;
   assign overrun   = overrun_q;

endmodule

// File: tb/tb_fre_calc.sv
// tb_fre_calc: directed vector table, randomized ops against an arithmetic model,
// plus overrun and mid-division reset sequences.
module tb_fre_calc;
   import fre_pkg::*;

   localparam int LAT_NORM = NUM_W + 5;
   localparam int LAT_ZERO = 5;

`ifdef FRE_CALC_ROUND_EN
   localparam logic [31:0] EXP_1_3    = 32'd66666667;
   localparam logic [31:0] EXP_1_400M = 32'd1;
`else
   localparam logic [31:0] EXP_1_3    = 32'd66666666;
   localparam logic [31:0] EXP_1_400M = 32'd0;
`endif

   typedef struct {
      logic [31:0] sig;
      logic [31:0] gate;
      logic [31:0] fre;
      logic        err;
      logic        sat;
      int          lat;
   } vec_t;

   logic        clk;
   logic        rst_or;
   logic        cnt_valid;
   logic [31:0] sig_cnt;
   logic [31:0] gate_cnt;
   logic [31:0] fre_out;
   logic        fre_valid;
   logic        busy;
   logic        div_err;
   logic        fre_sat;
   logic        overrun;

   int checks;
   int failures;

   fre_calc dut (
      .clk       (clk),
      .rst_or    (rst_or),
      .cnt_valid (cnt_valid),
      .sig_cnt   (sig_cnt),
      .gate_cnt  (gate_cnt),
      .fre_out   (fre_out),
      .fre_valid (fre_valid),
      .busy      (busy),
      .div_err   (div_err),
      .fre_sat   (fre_sat),
      .overrun   (overrun)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
      end
   endtask

   // Reference: exact integer arithmetic on 64-bit values.
   task automatic model(input logic [31:0] sig, input logic [31:0] gate,
                        output logic [31:0] fre, output logic err, output logic sat,
                        output int lat);
      longint unsigned num;
      longint unsigned q;
      if (gate == 32'd0) begin
         fre = 32'hFFFF_FFFF; err = 1'b1; sat = 1'b0; lat = LAT_ZERO;
      end else begin
         num = 64'(sig) * 64'd200000000;
`ifdef FRE_CALC_ROUND_EN
         num = num + 64'(gate) / 64'd2;
`endif
         q   = num / 64'(gate);
         err = 1'b0;
         lat = LAT_NORM;
         if (q > 64'h0000_0000_FFFF_FFFF) begin
            fre = 32'hFFFF_FFFF; sat = 1'b1;
         end else begin
            fre = q[31:0]; sat = 1'b0;
         end
      end
   endtask

   task automatic do_op(input string name, input logic [31:0] sig, input logic [31:0] gate,
                        input logic [31:0] exp_fre, input logic exp_err, input logic exp_sat,
                        input int exp_lat);
      int lat;
      int n_ovr;
      lat   = 0;
      n_ovr = 0;
      @(negedge clk);
      sig_cnt   = sig;
      gate_cnt  = gate;
      cnt_valid = 1'b1;
      for (int n = 1; n <= 200; n++) begin
         @(posedge clk);
         @(negedge clk);
         if (overrun) n_ovr++;
         if (n == 4) begin
            cnt_valid = 1'b0;
            sig_cnt   = $urandom;
            gate_cnt  = $urandom;
         end
         if (fre_valid) begin
            lat = n;
            break;
         end
      end
      cnt_valid = 1'b0;
      check($sformatf("%s latency", name), 64'(lat), 64'(exp_lat));
      check($sformatf("%s fre_out", name), 64'(fre_out), 64'(exp_fre));
      check($sformatf("%s div_err", name), 64'(div_err), 64'(exp_err));
      check($sformatf("%s fre_sat", name), 64'(fre_sat), 64'(exp_sat));
      check($sformatf("%s overrun", name), 64'(n_ovr), 64'd0);
      @(posedge clk);
      @(negedge clk);
      check($sformatf("%s pulse", name), 64'(fre_valid), 64'd0);
      check($sformatf("%s busy_end", name), 64'(busy), 64'd0);
      repeat (3) @(negedge clk);
   endtask

   vec_t vec[10];

   initial begin
      logic [31:0] r_sig, r_gate, e_fre;
      logic        e_err, e_sat;
      int          e_lat;
      int          n_ovr, n_val, lat;
      logic [31:0] fre_seen;

      checks    = 0;
      failures  = 0;
      rst_or    = 1'b1;
      cnt_valid = 1'b0;
      sig_cnt   = '0;
      gate_cnt  = '0;

      vec[0] = '{32'd10000000,   32'd200000000, 32'd10000000,   1'b0, 1'b0, LAT_NORM};
      vec[1] = '{32'd1,          32'd3,         EXP_1_3,        1'b0, 1'b0, LAT_NORM};
      vec[2] = '{32'd1,          32'd400000000, EXP_1_400M,     1'b0, 1'b0, LAT_NORM};
      vec[3] = '{32'd5,          32'd0,         32'hFFFF_FFFF,  1'b1, 1'b0, LAT_ZERO};
      vec[4] = '{32'hFFFF_FFFF,  32'd1,         32'hFFFF_FFFF,  1'b0, 1'b1, LAT_NORM};
      vec[5] = '{32'd10000000,   32'd200000000, 32'd10000000,   1'b0, 1'b0, LAT_NORM};
      vec[6] = '{32'd0,          32'd7,         32'd0,          1'b0, 1'b0, LAT_NORM};
      vec[7] = '{32'd21,         32'd1,         32'd4200000000, 1'b0, 1'b0, LAT_NORM};
      vec[8] = '{32'd22,         32'd1,         32'hFFFF_FFFF,  1'b0, 1'b1, LAT_NORM};
      vec[9] = '{32'd12345,      32'd200000,    32'd12345000,   1'b0, 1'b0, LAT_NORM};

      repeat (3) @(negedge clk);
      check("reset fre_out",   64'(fre_out),   64'd0);
      check("reset fre_valid", 64'(fre_valid), 64'd0);
      check("reset busy",      64'(busy),      64'd0);
      check("reset div_err",   64'(div_err),   64'd0);
      check("reset fre_sat",   64'(fre_sat),   64'd0);
      check("reset overrun",   64'(overrun),   64'd0);
      rst_or = 1'b0;
      repeat (2) @(negedge clk);

      for (int i = 0; i < 10; i++) begin
         do_op($sformatf("vec%0d", i), vec[i].sig, vec[i].gate, vec[i].fre,
               vec[i].err, vec[i].sat, vec[i].lat);
      end

      for (int i = 0; i < 30; i++) begin
         case ($urandom_range(0, 4))
            0: r_gate = $urandom_range(1, 16);
            1: r_gate = $urandom_range(100000000, 400000000);
            2: r_gate = $urandom;
            3: r_gate = $urandom_range(1000, 100000);
            default: r_gate = 32'd0;
         endcase
         r_sig = ($urandom_range(0, 1) == 0) ? $urandom : $urandom_range(0, 50000000);
         model(r_sig, r_gate, e_fre, e_err, e_sat, e_lat);
         do_op($sformatf("rnd%0d", i), r_sig, r_gate, e_fre, e_err, e_sat, e_lat);
      end

      // Second rise 20 cycles after the first: dropped, one overrun pulse, first result intact.
      n_ovr    = 0;
      n_val    = 0;
      lat      = 0;
      fre_seen = '0;
      @(negedge clk);
      sig_cnt  = 32'd10000000;
      gate_cnt = 32'd200000000;
      for (int n = 1; n <= 120; n++) begin
         cnt_valid = (n <= 4) || (n >= 20 && n <= 23);
         if (n == 20) begin
            sig_cnt  = 32'd1;
            gate_cnt = 32'd3;
         end
         @(posedge clk);
         @(negedge clk);
         if (n == 10) check("ovr busy", 64'(busy), 64'd1);
         if (overrun) n_ovr++;
         if (fre_valid) begin
            n_val++;
            if (lat == 0) lat = n;
            fre_seen = fre_out;
         end
      end
      cnt_valid = 1'b0;
      check("ovr pulses",  64'(n_ovr),    64'd1);
      check("ovr results", 64'(n_val),    64'd1);
      check("ovr latency", 64'(lat),      64'(LAT_NORM));
      check("ovr fre_out", 64'(fre_seen), 64'd10000000);
      repeat (3) @(negedge clk);

      // Reset during DIV after a saturated result: outputs clear at once, no result emerges.
      do_op("pre_rst", 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 1'b0, 1'b1, LAT_NORM);
      @(negedge clk);
      sig_cnt   = 32'd10000000;
      gate_cnt  = 32'd200000000;
      cnt_valid = 1'b1;
      for (int n = 1; n <= 30; n++) begin
         @(posedge clk);
         @(negedge clk);
         if (n == 4) cnt_valid = 1'b0;
      end
      check("mid busy", 64'(busy), 64'd1);
      #2 rst_or = 1'b1;
      #1;
      check("rst fre_out",   64'(fre_out),   64'd0);
      check("rst fre_sat",   64'(fre_sat),   64'd0);
      check("rst busy",      64'(busy),      64'd0);
      check("rst div_err",   64'(div_err),   64'd0);
      check("rst fre_valid", 64'(fre_valid), 64'd0);
      @(negedge clk);
      rst_or = 1'b0;
      n_val  = 0;
      for (int n = 1; n <= 100; n++) begin
         @(posedge clk);
         @(negedge clk);
         if (fre_valid) n_val++;
      end
      check("rst no result", 64'(n_val), 64'd0);
      do_op("post_rst", 32'd1, 32'd3, EXP_1_3, 1'b0, 1'b0, LAT_NORM);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
